eq2_comparator: RTL and testbench

- Registered WIDTH-bit equality comparator. Default WIDTH=2 gives the classic 2-bit eq2 function.
- Compares operands a and b and asserts aeqb when they are bit-for-bit identical.
- Sits in datapath/control logic wherever a synchronous match flag is needed.
- Provides a valid-qualified result and a saturating match counter for debug and observability.

---
 rtl/eq2_pkg.sv | 22 ++
 rtl/eq2_comparator_eq1_cell.sv | 10 +
 rtl/eq2_comparator.sv | 71 +++++++
 tb/tb_eq2_comparator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/eq2_pkg.sv
// Shared constants and the saturating-increment helper for the eq2 comparator.
package eq2_pkg;

  localparam int EQ_WIDTH  = 2;
  localparam int EQ_CNT_W  = 8;
  localparam int CNT_MAX_W = 32;

  // Returns cnt+1, or cnt unchanged once it has reached max_val (no wrap).
  function automatic logic [CNT_MAX_W-1:0] cnt_sat_inc(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic [CNT_MAX_W-1:0] max_val
  );
    logic [CNT_MAX_W-1:0] res;
    if (cnt >= max_val) begin
      res = cnt;
    end else begin
      res = cnt + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/eq2_comparator_eq1_cell.sv
// Single-bit equality cell: eq_i is high when both input bits match.
module eq1_cell (
  input  logic a_i,
  input  logic b_i,
  output logic eq_i
);

  assign eq_i = ~(a_i ^ b_i);

endmodule

// File: rtl/eq2_comparator.sv
// Registered WIDTH-bit equality comparator with valid qualifier and a
// saturating, clearable match counter for observability.
module eq2_comparator
  import eq2_pkg::*;
#(
  parameter int WIDTH = EQ_WIDTH,
  parameter int CNT_W = EQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             aeqb,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_cnt
);

  logic [WIDTH-1:0]     eq_bits_s;
  logic                 eq_s;
  logic                 aeqb_r;
  logic                 out_valid_r;
  logic [CNT_W-1:0]     match_cnt_r;
  logic [CNT_W-1:0]     cnt_next_s;
  logic [CNT_MAX_W-1:0] cnt_ext_s;
  logic [CNT_MAX_W-1:0] cnt_max_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    eq1_cell u_cell (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .eq_i (eq_bits_s[i])
    );
  end

  assign eq_s = &eq_bits_s;

  // Next counter value; clear wins over a coincident matching sample.
  always_comb begin
    cnt_ext_s = '0;
    cnt_max_s = '0;
    cnt_ext_s[CNT_W-1:0] = match_cnt_r;
    cnt_max_s[CNT_W-1:0] = {CNT_W{1'b1}};
    if (clr_cnt) begin
      cnt_next_s = '0;
    end else if (in_valid && eq_s) begin
      cnt_next_s = CNT_W'(cnt_sat_inc(cnt_ext_s, cnt_max_s));
    end else begin
      cnt_next_s = match_cnt_r;
    end
  end

  // Result, qualifier and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aeqb_r      <= 1'b0;
      out_valid_r <= 1'b0;
      match_cnt_r <= '0;
    end else begin
      aeqb_r      <= eq_s;
      out_valid_r <= in_valid;
      match_cnt_r <= cnt_next_s;
    end
  end

  assign aeqb      = aeqb_r;
  assign out_valid = out_valid_r;
  assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_eq2_comparator.sv
// Scoreboard bench for eq2_comparator: a default instance plus a CNT_W=2
// instance share stimulus so saturation is observed alongside normal counting.
module tb_eq2_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic       clr_cnt;
  logic       aeqb;
  logic       out_valid;
  logic [7:0] match_cnt;
  logic       aeqb_s;
  logic       out_valid_s;
  logic [1:0] match_cnt_s;

  typedef struct {
    logic aeqb;
    logic ov;
    int   c8;
    int   c2;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   m8     = 0;
  int   m2     = 0;

  always #5 clk = ~clk;

  eq2_comparator #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .aeqb(aeqb), .out_valid(out_valid), .match_cnt(match_cnt)
  );

  eq2_comparator #(.WIDTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .aeqb(aeqb_s), .out_valid(out_valid_s), .match_cnt(match_cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sample taken at a rising edge becomes the expected output.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      exp_t e;
      if (clr_cnt) begin
        m8 = 0;
        m2 = 0;
      end else if (in_valid && (a == b)) begin
        m8 = (m8 < 255) ? m8 + 1 : 255;
        m2 = (m2 < 3) ? m2 + 1 : 3;
      end
      e.aeqb = (a == b);
      e.ov   = in_valid;
      e.c8   = m8;
      e.c2   = m2;
      sb_q.push_back(e);
    end
  end

  always @(negedge rst_n) begin
    sb_q.delete();
    m8 = 0;
    m2 = 0;
  end

  // Monitor: one expected entry per registered output update.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      pops++;
      chk("sb_aeqb",      32'(aeqb),        32'(e.aeqb));
      chk("sb_out_valid", 32'(out_valid),   32'(e.ov));
      chk("sb_match_cnt", 32'(match_cnt),   e.c8);
      chk("sb_sat_aeqb",  32'(aeqb_s),      32'(e.aeqb));
      chk("sb_sat_cnt",   32'(match_cnt_s), e.c2);
    end
  end

  task automatic step(input logic [1:0] av, input logic [1:0] bv, input logic v, input logic c);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = v;
    clr_cnt  = c;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_aeqb"},      32'(aeqb),        32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_match_cnt"}, 32'(match_cnt),   32'd0);
    chk({tag, "_sat_cnt"},   32'(match_cnt_s), 32'd0);
  endtask

  logic [1:0] tt_a [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
  logic [1:0] tt_b [7] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};

  initial begin
    a        = 2'b11;
    b        = 2'b11;
    in_valid = 1'b1;
    clr_cnt  = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_immediate");
    repeat (3) @(negedge clk);
    chk_zero("reset_held");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      repeat (3) step(tt_a[i], tt_b[i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        step(2'(i), 2'(j), 1'b1, 1'b0);
      end
    end

    step(2'b10, 2'b10, 1'b0, 1'b0);
    step(2'b10, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("noval_aeqb", 32'(aeqb), 32'd1);
    chk("noval_out_valid", 32'(out_valid), 32'd0);

    a = 2'b01; b = 2'b01; in_valid = 1'b1; clr_cnt = 1'b1;
    repeat (5) step(2'b01, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    chk("count_five", 32'(match_cnt), 32'd5);
    chk("count_five_sat", 32'(match_cnt_s), 32'd3);
    a = 2'b01; b = 2'b01; in_valid = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    chk("clr_priority", 32'(match_cnt), 32'd0);
    chk("clr_priority_sat", 32'(match_cnt_s), 32'd0);
    clr_cnt = 1'b0;
    a = 2'b10; b = 2'b10;
    repeat (5) step(2'b10, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    chk("sat_six_wide", 32'(match_cnt), 32'd6);
    chk("sat_six", 32'(match_cnt_s), 32'd3);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_midstream");
    a = 2'b11; b = 2'b11;
    repeat (2) @(negedge clk);
    chk_zero("reset_mid_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_cnt1", 32'(match_cnt), 32'd1);
    @(negedge clk);
    chk("resume_cnt2", 32'(match_cnt), 32'd2);

    repeat (400) begin
      logic [1:0] ra;
      logic [1:0] rb;
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 1) == 0) ? ra : 2'($urandom_range(0, 3));
      step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    step(2'b00, 2'b01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_activity", 32'(pops > 400), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
